// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and parameter helpers for the UART transmit path
package uart_pkg;
   typedef enum logic [1:0] {
      FWD  = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } tx_state_e;
   function automatic int calc_baud_div(input int clk_rate, input int baud);
      return clk_rate / baud;
   endfunction
   function automatic int beat_width(input int word_len);
      return word_len + 1;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty
module sync_fifo #(
   parameter int Width = 9,
   parameter int Depth = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [Width-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [Width-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth+1)-1:0] count
);
   localparam int Aw = $clog2(Depth);
   localparam int Cw = $clog2(Depth+1);
   logic [Width-1:0] mem_q [Depth];
   logic [Aw:0]      wr_ptr_q, wr_ptr_d;
   logic [Aw:0]      rd_ptr_q, rd_ptr_d;
   logic [Aw:0]      used;
   logic             do_wr, do_rd;
   assign used     = wr_ptr_q - rd_ptr_q;
   assign empty    = wr_ptr_q == rd_ptr_q;
   assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {Aw{1'b0}}};
   assign count    = Cw'(used);
   assign do_wr    = wr_en && !full;
   assign do_rd    = rd_en && !empty;
   assign wr_ptr_d = wr_ptr_q + {{Aw{1'b0}}, do_wr};
   assign rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, do_rd};
   assign rd_data  = mem_q[rd_ptr_q[Aw-1:0]];
   // Storage is cleared on reset so the head reads as zero until the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_wr) mem_q[wr_ptr_q[Aw-1:0]] <= wr_data;
      end
   end
endmodule

// File: rtl/axis_uart_tx_fifo.sv
// axis_uart_tx_fifo: AXI-Stream slave that buffers bytes for the UART serializer
// and inserts an idle-line gap after every tlast frame.
module axis_uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int clk_rate = 100000000,
   parameter int Baud     = 115200,
   parameter int Word_len = 8,
   parameter int Depth    = 16,
   parameter int Gap_bits = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [Word_len-1:0]        s_axis_tdata,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   output logic                       s_axis_tready,
   output logic [Word_len-1:0]        tx_data,
   output logic                       tx_data_valid,
   output logic                       tx_data_last,
   input  logic                       tx_data_ready,
   output logic [$clog2(Depth+1)-1:0] fifo_count,
   output logic                       busy
);
   localparam int Baud_div   = calc_baud_div(clk_rate, Baud);
   localparam int Bw         = beat_width(Word_len);
   localparam int Gap_cycles = Gap_bits * Baud_div;
   localparam int Gw         = $clog2(Gap_cycles) + 1;
   localparam logic [Gw-1:0] Gap_last = Gw'((Gap_cycles > 0) ? Gap_cycles - 1 : 0);
   tx_state_e     state_q;
   logic [Gw-1:0] gap_cnt_q;
   logic [Bw-1:0] head;
   logic          full, empty, pop;
   sync_fifo #(
      .Width(Bw),
      .Depth(Depth)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (s_axis_tvalid && s_axis_tready),
      .wr_data({s_axis_tlast, s_axis_tdata}),
      .rd_en  (pop),
      .rd_data(head),
      .full   (full),
      .empty  (empty),
      .count  (fifo_count)
   );
   assign s_axis_tready             = rst_n && !full;
   assign {tx_data_last, tx_data}   = head;
   assign tx_data_valid             = !empty && state_q == FWD;
   assign pop                       = tx_data_valid && tx_data_ready;
   assign busy                      = !empty || state_q != FWD;
   // HOLD waits out the serializer's frame; its ready re-rising marks the stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FWD;
         gap_cnt_q <= '0;
      end else begin
         case (state_q)
            FWD:  if (pop && tx_data_last) state_q <= HOLD;
            HOLD: if (tx_data_ready) begin
               state_q   <= (Gap_bits == 0) ? FWD : GAP;
               gap_cnt_q <= '0;
            end
            GAP: begin
               gap_cnt_q <= gap_cnt_q + Gw'(1);
               if (gap_cnt_q == Gap_last) state_q <= FWD;
            end
            default: state_q <= FWD;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// tb_axis_uart_tx_fifo: scoreboard bench; dut uses a 2-bit gap, dut0 has the gap disabled.
module tb_axis_uart_tx_fifo;
   logic       clk = 0;
   logic       rst_n = 1;
   logic [7:0] tdata = 0;
   logic       tlast = 0;
   logic [1:0] tvalid = 0;
   logic [1:0] tready, txv, txl, bsy;
   logic [1:0] rdy = 2'b11;
   logic [7:0] txd [2];
   logic [2:0] cnt [2];
   logic [1:0] mode [2] = '{2'd0, 2'd0};
   logic [8:0] q [$];
   int         checks = 0, errors = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_uart_tx_fifo #(.clk_rate(16), .Baud(1), .Word_len(8), .Depth(4), .Gap_bits(2)) dut (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid[0]),
      .s_axis_tlast(tlast), .s_axis_tready(tready[0]), .tx_data(txd[0]),
      .tx_data_valid(txv[0]), .tx_data_last(txl[0]), .tx_data_ready(rdy[0]),
      .fifo_count(cnt[0]), .busy(bsy[0]));

   axis_uart_tx_fifo #(.clk_rate(16), .Baud(1), .Word_len(8), .Depth(4), .Gap_bits(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid[1]),
      .s_axis_tlast(tlast), .s_axis_tready(tready[1]), .tx_data(txd[1]),
      .tx_data_valid(txv[1]), .tx_data_last(txl[1]), .tx_data_ready(rdy[1]),
      .fifo_count(cnt[1]), .busy(bsy[1]));

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Serializer model: mode 0 drops ready for one 160-cycle frame per accepted byte,
   // mode 1 holds ready low, mode 2 holds it high.
   initial begin
      int n [2] = '{0, 0};
      logic [1:0] hs;
      forever begin
         @(negedge clk);
         hs = txv & rdy;
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (mode[i] == 1) rdy[i] = 0;
            else if (mode[i] == 2) rdy[i] = 1;
            else if (hs[i]) begin
               rdy[i] = 0;
               n[i] = 160;
            end else if (n[i] > 0) begin
               n[i]--;
               if (n[i] == 0) rdy[i] = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && txv[0] && rdy[0]) begin
         check("sb_expected_beat", int'(q.size() > 0), 1);
         if (q.size() > 0) check("sb_beat", int'({txl[0], txd[0]}), int'(q.pop_front()));
      end
   end

   task automatic push(input int d, input logic [7:0] b, input logic l);
      int n = 0;
      logic ok = 0;
      tdata = b;
      tlast = l;
      tvalid[d] = 1;
      while (!ok && n < 2000) begin
         @(negedge clk);
         ok = tready[d];
         @(posedge clk);
         #1;
         n++;
      end
      tvalid[d] = 0;
      check("push_accepted", int'(ok), 1);
      if (ok && d == 0) q.push_back({l, b});
   endtask

   task automatic wait_for(input int d, input int kind, input logic [7:0] b);
      int n = 0;
      logic hit = 0;
      while (!hit && n < 1000) begin
         @(negedge clk);
         n++;
         hit = kind == 0 ? (txv[d] && rdy[d] && txd[d] == b) : kind == 1 ? rdy[d] : txv[d];
      end
      check("wait_budget", int'(hit), 1);
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (!(rdy[d] && !bsy[d] && q.size() == 0) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_budget", int'(n < 2000), 1);
   endtask

   // Valid for the next packet rises Gap_bits*Baud_div clocks after the edge that
   // samples ready high, i.e. gap+1 negedge samples after the one that first sees it.
   task automatic run_pkt(input int d, input int gap);
      int t2, t3;
      fork
         begin
            push(d, 8'h11, 0);
            push(d, 8'h22, 1);
            push(d, 8'h33, 0);
         end
         begin
            wait_for(d, 0, 8'h11);
            wait_for(d, 1, 8'h00);
            check("b2b_valid", int'(txv[d]), 1);
            check("b2b_beat", int'({txl[d], txd[d]}), 'h122);
            wait_for(d, 1, 8'h00);
            t2 = cyc;
            check("gap_valid_low", int'(txv[d]), 0);
            wait_for(d, 2, 8'h00);
            t3 = cyc;
            check("gap_len", t3 - t2, gap);
            check("gap_next_data", int'(txd[d]), 'h33);
         end
      join
      wait_idle(d);
   endtask

   initial begin
      #1 rst_n = 0;
      #11;
      check("rst_tready", int'(tready[0]), 0);
      check("rst_valid", int'(txv[0]), 0);
      check("rst_data", int'(txd[0]), 0);
      check("rst_last", int'(txl[0]), 0);
      check("rst_count", int'(cnt[0]), 0);
      check("rst_busy", int'(bsy[0]), 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      check("tready_after_reset", int'(tready[0]), 1);
      push(0, 8'hA5, 0);
      check("s1_valid", int'(txv[0]), 1);
      check("s1_data", int'(txd[0]), 'hA5);
      check("s1_count", int'(cnt[0]), 1);
      @(posedge clk);
      #1;
      check("s1_count_after_pop", int'(cnt[0]), 0);
      check("s1_busy", int'(bsy[0]), 0);
      wait_idle(0);
      mode[0] = 1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 1; i <= 4; i++) begin
         push(0, 8'(i), 0);
         check("s2_tready", int'(tready[0]), i < 4 ? 1 : 0);
      end
      check("s2_count_full", int'(cnt[0]), 4);
      fork
         push(0, 8'd5, 0);
         mode[0] = 2;
      join
      wait_idle(0);
      mode[0] = 0;
      run_pkt(0, 33);
      run_pkt(1, 1);
      mode[0] = 2;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) push(0, 8'h40 + 8'(i), 0);
      wait_idle(0);
      mode[0] = 0;
      push(0, 8'h77, 1);
      push(0, 8'h01, 0);
      push(0, 8'h02, 0);
      push(0, 8'h03, 0);
      wait_for(0, 1, 8'h00);
      repeat (5) @(posedge clk);
      #3;
      check("s6_count_in_gap", int'(cnt[0]), 3);
      check("s6_valid_in_gap", int'(txv[0]), 0);
      rst_n = 0;
      #1;
      check("s6_rst_valid", int'(txv[0]), 0);
      check("s6_rst_data", int'(txd[0]), 0);
      check("s6_rst_last", int'(txl[0]), 0);
      check("s6_rst_count", int'(cnt[0]), 0);
      check("s6_rst_busy", int'(bsy[0]), 0);
      check("s6_rst_tready", int'(tready[0]), 0);
      q.delete();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      push(0, 8'h5A, 0);
      check("s6_valid_no_gap", int'(txv[0]), 1);
      check("s6_data", int'(txd[0]), 'h5A);
      wait_idle(0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
      $fatal(1);
   end
endmodule
